demux_deser4: RTL and testbench
===============================

// Module: demux_deser4
// PURPOSE
//  - Receive end of the 4:1 mux serializer: accepts one bit per handshake, routes bit k to lane k, presents an N-bit word.
//  - Lane order matches the mux select order: first bit received -> y[0], last -> y[N-1].
//  - Sits after a counter-driven mux serializer link; single-entry output buffer with valid/ready backpressure.
// PARAMETERS
//  - N       4                     lanes per word; legal N >= 2
//  - CNT_W   $clog2(N+1), local    width of the lane-select counter
// PORTS
//  - clk          in   1       single clock, rising edge
//  - rst          in   1       synchronous, active-high reset
//  - frame_sync   in   1       restart the frame: discard partial word, next bit is lane 0
//  - bit_in       in   1       serial data bit
//  - bit_valid    in   1       bit_in is valid this cycle
//  - bit_ready    out  1       block accepts bit_in this cycle
//  - y            out  N       assembled word; y[k] = k-th bit of the frame
//  - y_valid      out  1       y holds a complete, unconsumed word
//  - y_ready      in   1       consumer takes y this cycle
//  - parity_err   out  1       parity mismatch for current y (DEMUX_DESER4_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (rst=1 at edge): sel=0, partial word=0, y=0, y_valid=0, parity_err=0. Overrides all else, including mid-frame.
//  - Bit transfer: bit_valid && bit_ready at the edge. Stores bit_in in lane sel, then sel++.
//  - Completion: a transfer with sel==FRAME_LAST. FRAME_LAST=N-1, or N with parity.
//    - Completion loads y (the completing bit is included) and sets y_valid=1.
//    - sel wraps to 0.
//  - Latency: y_valid rises 1 cycle after the completing transfer.
//  - Output handshake:
//    - y, parity_err stay stable while y_valid && !y_ready.
//    - y_valid clears on y_valid && y_ready unless a completion occurs in the same cycle.
//    - Same-cycle completion and consume: the new word is loaded and y_valid stays 1 with no bubble.
//  - bit_ready = !(sel==FRAME_LAST && y_valid && !y_ready); combinational from state and y_ready.
//    - Bits for lanes before the last are always accepted, even while the buffer is full.
//  - frame_sync: sel<=0 and partial lanes are discarded. y and y_valid are unaffected.
//    - If bit_valid is also high, that bit is accepted as lane 0 (sel<=1).
//    - frame_sync has priority over completion: no word is emitted that cycle.
//  - State machine: FILL (sel<FRAME_LAST) -> LAST (sel==FRAME_LAST) -> FILL on transfer or frame_sync.
//    - With parity: FILL -> PAR (sel==N) -> FILL.
//  - No overflow: backpressure only stalls the completing bit, so no word is ever dropped.
// CONFIGURATION
//  - Macro DEMUX_DESER4_PARITY_EN.
//  - Defined: each frame is N data bits followed by 1 even-parity bit (frame = N+1 bits).
//    - parity_err = ^{data, parity} is registered with y and follows the same hold rules.
//    - The word is delivered even when parity_err=1.
//  - Undefined: frame = N bits; parity_err driven constant 0; no PAR state.
// STRUCTURE
//  - Package demux_pkg:
//    - typedef enum logic [1:0] {FILL, LAST, PAR} deser_state_t
//    - function clog2p1(n) for counter widths
//  - Sub-module out_reg1: one-entry valid/ready holding register for {parity_err, y}.
//    - Parameter W.
//    - Ports: load/ld_data, y_ready, y_valid, q.
//  - Top level holds: sel counter, lane registers, state logic, bit_ready.
// TESTING
//  - Reset, then N=4 stream 1,0,1,1 with y_ready=1 -> y=4'b1101, y_valid high for exactly 1 cycle, 1 cycle after last bit.
//  - Hold y_ready=0 after word 4'b0110; send next 4 bits 1,1,1,1 -> first 3 accepted, bit_ready=0 on 4th, y stays 0110.
//    - Raise y_ready -> 4th bit accepted that cycle; then y=4'b1111.
//  - Back-to-back continuous bits, y_ready=1 -> y_valid stays high across consecutive words, no bubbles, no lost bits.
//  - frame_sync after 2 bits (1,1), then 0,0,1,0 -> y=4'b0100; the partial 1,1 never appears.
//  - Assert rst mid-frame after 3 bits -> all outputs 0 next cycle; next 4 bits form a complete new word.
//  - PARITY_EN: data 1,0,1,1 then parity 1 -> y=4'b1101, parity_err=0; parity bit 0 instead -> parity_err=1, word still delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the 4:1 serial demux/deserializer.
// Parity framing is selected with DEMUX_DESER4_PARITY_EN.
package demux_pkg;

    typedef enum logic [1:0] {
        FILL,
        LAST,
        PAR
    } deser_state_t;

    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/out_reg1.sv
// One-entry valid/ready holding register for the assembled word.
// Upstream only loads when the slot is empty or being drained.
module out_reg1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] ld_data,
    input  logic         y_ready,
    output logic         y_valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            y_valid <= 1'b0;
        end else if (load) begin
            q       <= ld_data;
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_deser4.sv
// Serial-to-parallel receiver: bit k of each frame lands in lane k.
// Define DEMUX_DESER4_PARITY_EN for an extra trailing even-parity bit.
module demux_deser4
    import demux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_sync,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         bit_ready,
    output logic [N-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         parity_err
);

    localparam int CNT_W = clog2p1(N);
`ifdef DEMUX_DESER4_PARITY_EN
    localparam int FRAME_LAST = N;
    localparam int OW = N + 1;
`else
    localparam int FRAME_LAST = N - 1;
    localparam int OW = N;
`endif

    logic [CNT_W-1:0] sel;
    logic [N-1:0]     lanes;
    logic [N-1:0]     word;
    logic [OW-1:0]    ld_data;
    logic [OW-1:0]    q;
    deser_state_t     state;
    logic             xfer;
    logic             done;

    always_comb begin
        state = FILL;
        if (sel == CNT_W'(FRAME_LAST)) begin
`ifdef DEMUX_DESER4_PARITY_EN
            state = PAR;
`else
            state = LAST;
`endif
        end
    end

    // Only the completing bit can be stalled by a full output slot.
    assign bit_ready = !(state != FILL && y_valid && !y_ready);
    assign xfer      = bit_valid && bit_ready;
    assign done      = xfer && state != FILL && !frame_sync;

    always_comb begin
        word = lanes;
`ifndef DEMUX_DESER4_PARITY_EN
        word[N-1] = bit_in;
`endif
    end

`ifdef DEMUX_DESER4_PARITY_EN
    assign ld_data = {^{word, bit_in}, word};
`else
    assign ld_data = word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sel   <= '0;
            lanes <= '0;
        end else if (frame_sync) begin
            sel   <= '0;
            lanes <= '0;
            if (xfer) begin
                lanes[0] <= bit_in;
                sel      <= CNT_W'(1);
            end
        end else if (done) begin
            sel   <= '0;
            lanes <= '0;
        end else if (xfer) begin
            for (int k = 0; k < N; k++) begin
                if (sel == CNT_W'(k)) lanes[k] <= bit_in;
            end
            sel <= sel + CNT_W'(1);
        end
    end

    out_reg1 #(
        .W(OW)
    ) u_out (
        .clk    (clk),
        .rst    (rst),
        .load   (done),
        .ld_data(ld_data),
        .y_ready(y_ready),
        .y_valid(y_valid),
        .q      (q)
    );

`ifdef DEMUX_DESER4_PARITY_EN
    assign y          = q[N-1:0];
    assign parity_err = q[N];
`else
    assign y          = q;
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_deser4.sv
// Bench for demux_deser4: frame-level model plus directed literal checks.
// Build with DEMUX_DESER4_PARITY_EN to cover the parity framing.
module tb_demux_deser4;

    localparam int N = 4;
`ifdef DEMUX_DESER4_PARITY_EN
    localparam int FLEN = N + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FLEN = N;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         frame_sync = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_ready;
    logic [N-1:0] y;
    logic         y_valid;
    logic         y_ready = 1'b1;
    logic         parity_err;

    int n_cmp = 0;
    int n_bad = 0;

    demux_deser4 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_sync(frame_sync),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame model: bits collected so far, and the word waiting for the consumer.
    int           m_cnt = 0;
    logic         m_bits[N+1];
    logic [N-1:0] m_y = '0;
    logic         m_valid = 1'b0;
    logic         m_perr = 1'b0;
    logic         m_live = 1'b0;

    always @(posedge clk) begin
        bit m_rdy;
        bit acc;
        m_rdy = !(m_cnt == FLEN - 1 && m_valid && !y_ready);
        acc = bit_valid && m_rdy;
        if (rst) begin
            m_cnt = 0;
            m_y = '0;
            m_valid = 1'b0;
            m_perr = 1'b0;
            m_live = 1'b1;
        end else begin
            if (m_valid && y_ready) m_valid = 1'b0;
            if (frame_sync) begin
                m_cnt = 0;
                if (acc) begin
                    m_bits[0] = bit_in;
                    m_cnt = 1;
                end
            end else if (acc) begin
                m_bits[m_cnt] = bit_in;
                m_cnt++;
                if (m_cnt == FLEN) begin
                    int ones;
                    ones = 0;
                    for (int k = 0; k < FLEN; k++) ones += int'(m_bits[k]);
                    for (int k = 0; k < N; k++) m_y[k] = m_bits[k];
                    m_perr = PAR && (ones % 2 == 1);
                    m_valid = 1'b1;
                    m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_y_valid", 32'(y_valid), 32'(m_valid));
            chk("m_bit_ready", 32'(bit_ready),
                32'(!(m_cnt == FLEN - 1 && m_valid && !y_ready)));
            if (m_valid) begin
                chk("m_y", 32'(y), 32'(m_y));
                chk("m_parity_err", 32'(parity_err), 32'(m_perr));
            end
        end
    end

    task automatic send_bit(input logic b, input logic fs);
        bit acc;
        bit_valid = 1'b1;
        bit_in = b;
        frame_sync = fs;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bit_ready;
            @(posedge clk);
            #1;
        end
        frame_sync = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic bad);
        for (int k = 0; k < N; k++) send_bit(w[k], 1'b0);
        if (PAR) send_bit(^w ^ bad, 1'b0);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_bit_ready", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1,0,1,1 -> 1101, valid for one cycle only
        y_ready = 1'b1;
        send_word(4'b1101, 1'b0);
        bit_valid = 1'b0;
        @(negedge clk);
        chk("w1_valid", 32'(y_valid), 32'd1);
        chk("w1_y", 32'(y), 32'hd);
        chk("w1_perr", 32'(parity_err), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w1_drop", 32'(y_valid), 32'd0);
        idle(1);

        // Backpressure: full slot stalls only the completing bit
        y_ready = 1'b0;
        send_word(4'b0110, 1'b0);
        bit_valid = 1'b0;
        @(negedge clk);
        chk("bp_y0", 32'(y), 32'h6);
        @(posedge clk);
        #1;
        for (int k = 0; k < FLEN - 1; k++) send_bit(1'b1, 1'b0);
        bit_valid = 1'b1;
        bit_in = PAR ? 1'b0 : 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall", 32'(bit_ready), 32'd0);
            chk("bp_hold_y", 32'(y), 32'h6);
            chk("bp_hold_v", 32'(y_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        y_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        @(negedge clk);
        chk("bp_y1", 32'(y), 32'hf);
        chk("bp_v1", 32'(y_valid), 32'd1);
        idle(2);

        // Back-to-back words, no idle between them
        send_word(4'ha, 1'b0);
        send_word(4'h5, 1'b0);
        send_word(4'hc, 1'b0);
        bit_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last", 32'(y), 32'hc);
        idle(2);

        // frame_sync after 1,1; restart carries lane 0
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        if (PAR) send_bit(1'b1, 1'b0);
        bit_valid = 1'b0;
        @(negedge clk);
        chk("fs_y", 32'(y), 32'h4);
        chk("fs_valid", 32'(y_valid), 32'd1);
        idle(2);

        // Reset mid-frame
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(y_valid), 32'd0);
        chk("mrst_y", 32'(y), 32'd0);
        chk("mrst_perr", 32'(parity_err), 32'd0);
        @(posedge clk);
        #1;
        send_word(4'b0011, 1'b0);
        bit_valid = 1'b0;
        @(negedge clk);
        chk("mrst_word", 32'(y), 32'h3);
        chk("mrst_wvalid", 32'(y_valid), 32'd1);
        idle(2);

        // Wrong parity bit (no effect on a plain build)
        send_word(4'b1101, 1'b1);
        bit_valid = 1'b0;
        @(negedge clk);
        chk("perr_y", 32'(y), 32'hd);
        chk("perr_flag", 32'(parity_err), 32'(PAR));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
